// File: rtl/id_stage.sv
// Decode / register-fetch stage: 32-bit MIPS decode plus 32x32 register file with
// same-cycle writeback bypass, feeding an ID/EX register with stall and flush.
module id_stage #(
    parameter int WIDTH = 32,
    parameter int NREGS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      instr,
    input  logic             instr_valid,
    input  logic             stall,
    input  logic             flush,
    input  logic             wb_en,
    input  logic [4:0]       wb_addr,
    input  logic [WIDTH-1:0] wb_data,
    output logic             ALUSrc,
    output logic [3:0]       ALUOp,
    output logic [15:0]      Immediate,
    output logic [WIDTH-1:0] Reg1,
    output logic [WIDTH-1:0] Reg2,
    output logic [4:0]       WriteReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             MemToReg,
    output logic [1:0]       Branch,
    output logic             ex_valid,
    output logic             illegal
);

    typedef enum logic [5:0] {
        OP_RTYPE = 6'b000000,
        OP_ADDI  = 6'b001000,
        OP_ANDI  = 6'b001100,
        OP_ORI   = 6'b001101,
        OP_XORI  = 6'b001110,
        OP_SLTI  = 6'b001010,
        OP_LUI   = 6'b001111,
        OP_LW    = 6'b100011,
        OP_SW    = 6'b101011,
        OP_BEQ   = 6'b000100,
        OP_BNE   = 6'b000101
    } opcode_e;

    typedef struct packed {
        logic             alusrc;
        logic [3:0]       aluop;
        logic [15:0]      imm;
        logic [WIDTH-1:0] reg1;
        logic [WIDTH-1:0] reg2;
        logic [4:0]       wreg;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic             memtoreg;
        logic [1:0]       branch;
        logic             valid;
        logic             illegal;
    } idex_t;

    logic [WIDTH-1:0] rf_q [NREGS];
    logic [4:0]       rs, rt;
    logic [WIDTH-1:0] rd1, rd2;
    opcode_e          op;
    idex_t            dec, idex_d, idex_q;
    logic             legal;

    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign op = opcode_e'(instr[31:26]);

    // r0 is never written, so it always reads back as zero; bypass skips r0 too.
    assign rd1 = (wb_en && wb_addr != '0 && wb_addr == rs) ? wb_data : rf_q[rs];
    assign rd2 = (wb_en && wb_addr != '0 && wb_addr == rt) ? wb_data : rf_q[rt];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        dec.imm   = instr[15:0];
        dec.reg1  = rd1;
        dec.reg2  = rd2;
        dec.valid = 1'b1;
        case (op)
            OP_RTYPE: begin dec.aluop = 4'b0010; dec.wreg = instr[15:11]; dec.regwrite = 1'b1; end
            OP_ADDI:  begin dec.aluop = 4'b0000; dec.alusrc = 1'b1; dec.wreg = rt; dec.regwrite = 1'b1; end
            OP_ANDI:  begin dec.aluop = 4'b0011; dec.alusrc = 1'b1; dec.wreg = rt; dec.regwrite = 1'b1; end
            OP_ORI:   begin dec.aluop = 4'b0100; dec.alusrc = 1'b1; dec.wreg = rt; dec.regwrite = 1'b1; end
            OP_XORI:  begin dec.aluop = 4'b0110; dec.alusrc = 1'b1; dec.wreg = rt; dec.regwrite = 1'b1; end
            OP_SLTI:  begin dec.aluop = 4'b0101; dec.alusrc = 1'b1; dec.wreg = rt; dec.regwrite = 1'b1; end
            OP_LUI:   begin dec.aluop = 4'b0111; dec.alusrc = 1'b1; dec.wreg = rt; dec.regwrite = 1'b1; end
            OP_LW: begin
                dec.aluop    = 4'b0000;
                dec.alusrc   = 1'b1;
                dec.wreg     = rt;
                dec.regwrite = 1'b1;
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
            end
            OP_SW:    begin dec.aluop = 4'b0000; dec.alusrc = 1'b1; dec.memwrite = 1'b1; end
            OP_BEQ:   begin dec.aluop = 4'b0001; dec.branch = 2'b01; end
            OP_BNE:   begin dec.aluop = 4'b0001; dec.branch = 2'b10; end
            default:  legal = 1'b0;
        endcase
    end

    always_comb begin
        idex_d = idex_q;
        if (flush) begin
            idex_d = '0;
        end else if (stall) begin
            idex_d.illegal = 1'b0;
        end else if (!instr_valid) begin
            idex_d = '0;
        end else if (legal) begin
            idex_d = dec;
        end else begin
            idex_d         = '0;
            idex_d.illegal = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) idex_q <= '0;
        else     idex_q <= idex_d;
    end

    assign ALUSrc    = idex_q.alusrc;
    assign ALUOp     = idex_q.aluop;
    assign Immediate = idex_q.imm;
    assign Reg1      = idex_q.reg1;
    assign Reg2      = idex_q.reg2;
    assign WriteReg  = idex_q.wreg;
    assign RegWrite  = idex_q.regwrite;
    assign MemRead   = idex_q.memread;
    assign MemWrite  = idex_q.memwrite;
    assign MemToReg  = idex_q.memtoreg;
    assign Branch    = idex_q.branch;
    assign ex_valid  = idex_q.valid;
    assign illegal   = idex_q.illegal;

endmodule
